// File: rtl/maze_engine.sv
// Grid maze game: debounced five-button control, move/goal/budget FSM, and a
// registered RGB565 pixel generator for an OLED scan of the grid.
module maze_engine #(
  parameter int                         GRID_W     = 12,
  parameter int                         GRID_H     = 8,
  parameter int                         CELL_PX    = 8,
  parameter logic [GRID_W*GRID_H-1:0]   WALL_MAP   = '0,
  parameter int                         START_X    = 0,
  parameter int                         START_Y    = 0,
  parameter int                         GOAL_X     = GRID_W - 1,
  parameter int                         GOAL_Y     = GRID_H - 1,
  parameter int                         MAX_MOVES  = 63,
  parameter int                         DEB_CYCLES = 65535
) (
  input  logic        basys_clock,
  input  logic        reset,
  input  logic [4:0]  pb,
  input  logic        en,
  input  logic        curr_colour,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  output logic [15:0] oled_data,
  output logic [2:0]  wire_to_cut,
  output logic [1:0]  state,
  output logic [3:0]  player_x,
  output logic [2:0]  player_y,
  output logic [6:0]  moves
);

  localparam int CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam bit CP_POW2 = (CELL_PX & (CELL_PX - 1)) == 0;
  localparam int CP_LOG  = $clog2(CELL_PX);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WON = 2'd2, LOST = 2'd3} state_t;

  function automatic logic wall_at(input int cx, input int cy);
    logic [GRID_W*GRID_H-1:0] m;
    if (cx < 0 || cy < 0 || cx >= GRID_W || cy >= GRID_H) return 1'b0;
    m = WALL_MAP >> (cy * GRID_W + cx);
    return m[0];
  endfunction

  logic [4:0]       r_sync1, r_sync2, r_deb, r_deb_q;
  logic [CNT_W-1:0] r_cnt [5];
  logic [4:0]       w_ev;

  // Stage p0: synchronise, debounce and edge-detect each button
  always_ff @(posedge basys_clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= pb;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_ev = r_deb & ~r_deb_q;

  state_t      r_state, w_nstate;
  logic [3:0]  r_px, w_npx;
  logic [2:0]  r_py, w_npy;
  logic [6:0]  r_moves, w_nmoves, w_inc;
  logic [2:0]  r_wire, w_nwire;
  int          w_tx, w_ty;
  logic        w_dir, w_ok;

  // Stage p1: game state register
  always_ff @(posedge basys_clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_px    <= 4'(START_X);
      r_py    <= 3'(START_Y);
      r_moves <= '0;
      r_wire  <= '0;
    end else begin
      r_state <= w_nstate;
      r_px    <= w_npx;
      r_py    <= w_npy;
      r_moves <= w_nmoves;
      r_wire  <= w_nwire;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_npx    = r_px;
    w_npy    = r_py;
    w_nmoves = r_moves;
    w_nwire  = r_wire;
    w_inc    = r_moves + 7'd1;
    w_tx     = int'(r_px);
    w_ty     = int'(r_py);
    w_dir    = 1'b1;
    // Only the highest-priority direction is considered; the rest are dropped
    if (w_ev[1])      w_ty = w_ty - 1;
    else if (w_ev[4]) w_ty = w_ty + 1;
    else if (w_ev[2]) w_tx = w_tx - 1;
    else if (w_ev[3]) w_tx = w_tx + 1;
    else              w_dir = 1'b0;
    w_ok = w_dir && w_tx >= 0 && w_tx < GRID_W && w_ty >= 0 && w_ty < GRID_H &&
           !wall_at(w_tx, w_ty);

    case (r_state)
      IDLE: begin
        w_npx    = 4'(START_X);
        w_npy    = 3'(START_Y);
        w_nmoves = '0;
        w_nwire  = '0;
        if (w_ev[0]) w_nstate = PLAY;
      end
      PLAY: begin
        if (w_ok) begin
          w_npx    = 4'(w_tx);
          w_npy    = 3'(w_ty);
          w_nmoves = w_inc;
          if (w_tx == GOAL_X && w_ty == GOAL_Y) begin
            w_nstate = WON;
            w_nwire  = w_inc[2:0];
          end else if (int'(w_inc) >= MAX_MOVES) begin
            w_nstate = LOST;
          end
        end
      end
      default: begin
        if (w_ev[0]) begin
          w_nstate = IDLE;
          w_npx    = 4'(START_X);
          w_npy    = 3'(START_Y);
          w_nmoves = '0;
          w_nwire  = '0;
        end
      end
    endcase

    if (!en) begin
      w_nstate = IDLE;
      w_npx    = 4'(START_X);
      w_npy    = 3'(START_Y);
      w_nmoves = '0;
      w_nwire  = '0;
    end
  end

  int          w_cx, w_cy;
  logic [15:0] w_pix;
  logic [15:0] r_oled;

  always_comb begin
    w_cx  = CP_POW2 ? (int'(x) >> CP_LOG) : (int'(x) / CELL_PX);
    w_cy  = CP_POW2 ? (int'(y) >> CP_LOG) : (int'(y) / CELL_PX);
    w_pix = 16'h0000;
    if (int'(x) >= GRID_W * CELL_PX || int'(y) >= GRID_H * CELL_PX)
      w_pix = 16'h0000;
    else if (w_cx == int'(r_px) && w_cy == int'(r_py))
      w_pix = curr_colour ? 16'h001F : 16'hF800;
    else if (w_cx == GOAL_X && w_cy == GOAL_Y)
      w_pix = 16'h07E0;
    else if (wall_at(w_cx, w_cy))
      w_pix = 16'hFFFF;
  end

  // Stage p2: registered pixel output
  always_ff @(posedge basys_clock) begin
    if (reset) r_oled <= '0;
    else       r_oled <= w_pix;
  end

  assign oled_data   = r_oled;
  assign wire_to_cut = r_wire;
  assign state       = r_state;
  assign player_x    = r_px;
  assign player_y    = r_py;
  assign moves       = r_moves;

endmodule

// File: tb/tb_maze_engine.sv
// Bench for maze_engine: four configurations, pixel vector table, directed
// game sequences and a randomized press-level reference model.
module tb_maze_engine;

  localparam logic [95:0] WMAP1 = 96'h0004_0400_2000_8002;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  pb [4];
  logic        en [4];
  logic        col;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] oled [4];
  logic [2:0]  wo [4];
  logic [1:0]  st [4];
  logic [3:0]  pxo [4];
  logic [2:0]  pyo [4];
  logic [6:0]  mv [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maze_engine #(.DEB_CYCLES(4)) d0 (
    .basys_clock(clk), .reset(rst), .pb(pb[0]), .en(en[0]), .curr_colour(col),
    .x(x), .y(y), .oled_data(oled[0]), .wire_to_cut(wo[0]), .state(st[0]),
    .player_x(pxo[0]), .player_y(pyo[0]), .moves(mv[0]));

  maze_engine #(.DEB_CYCLES(4), .WALL_MAP(WMAP1), .GOAL_X(3), .GOAL_Y(2), .MAX_MOVES(12)) d1 (
    .basys_clock(clk), .reset(rst), .pb(pb[1]), .en(en[1]), .curr_colour(col),
    .x(x), .y(y), .oled_data(oled[1]), .wire_to_cut(wo[1]), .state(st[1]),
    .player_x(pxo[1]), .player_y(pyo[1]), .moves(mv[1]));

  maze_engine #(.DEB_CYCLES(4), .GOAL_X(2), .GOAL_Y(0), .MAX_MOVES(2)) d2 (
    .basys_clock(clk), .reset(rst), .pb(pb[2]), .en(en[2]), .curr_colour(col),
    .x(x), .y(y), .oled_data(oled[2]), .wire_to_cut(wo[2]), .state(st[2]),
    .player_x(pxo[2]), .player_y(pyo[2]), .moves(mv[2]));

  maze_engine #(.DEB_CYCLES(4), .MAX_MOVES(3)) d3 (
    .basys_clock(clk), .reset(rst), .pb(pb[3]), .en(en[3]), .curr_colour(col),
    .x(x), .y(y), .oled_data(oled[3]), .wire_to_cut(wo[3]), .state(st[3]),
    .player_x(pxo[3]), .player_y(pyo[3]), .moves(mv[3]));

  typedef struct {
    int          inst;
    int          px;
    int          py;
    logic        c;
    logic [15:0] exp;
  } pix_t;

  pix_t tbl [12];

  // press-level reference model of instance d1
  int m_state, m_x, m_y, m_moves, m_wire;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_game(input int d, input string nm, input int s, input int px,
                          input int py, input int m, input int w);
    chk($sformatf("%s.state%0d", nm, d), int'(st[d]), s);
    chk($sformatf("%s.px%0d", nm, d), int'(pxo[d]), px);
    chk($sformatf("%s.py%0d", nm, d), int'(pyo[d]), py);
    chk($sformatf("%s.moves%0d", nm, d), int'(mv[d]), m);
    chk($sformatf("%s.wire%0d", nm, d), int'(wo[d]), w);
  endtask

  task automatic press(input int d, input logic [4:0] m);
    pb[d] = m;
    tick(12);
    pb[d] = 5'd0;
    tick(12);
  endtask

  function automatic bit m_wall(input int cx, input int cy);
    return WMAP1[cy * 12 + cx];
  endfunction

  task automatic model_press(input logic [4:0] m);
    int nx, ny;
    nx = m_x;
    ny = m_y;
    if (m_state == 0) begin
      if (m[0]) m_state = 1;
    end else if (m_state == 1) begin
      if (m[1]) ny = m_y - 1;
      else if (m[4]) ny = m_y + 1;
      else if (m[2]) nx = m_x - 1;
      else if (m[3]) nx = m_x + 1;
      if ((nx != m_x || ny != m_y) && nx >= 0 && nx < 12 && ny >= 0 && ny < 8 &&
          !m_wall(nx, ny)) begin
        m_x = nx;
        m_y = ny;
        m_moves++;
        if (nx == 3 && ny == 2) begin
          m_state = 2;
          m_wire  = m_moves % 8;
        end else if (m_moves >= 12) begin
          m_state = 3;
        end
      end
    end else if (m[0]) begin
      m_state = 0; m_x = 0; m_y = 0; m_moves = 0; m_wire = 0;
    end
  endtask

  function automatic int model_pix(input int px, input int py, input logic c);
    int cx, cy;
    if (px >= 96 || py >= 64) return 0;
    cx = px / 8;
    cy = py / 8;
    if (cx == m_x && cy == m_y) return c ? 32'h001F : 32'hF800;
    if (cx == 3 && cy == 2) return 32'h07E0;
    if (m_wall(cx, cy)) return 32'hFFFF;
    return 0;
  endfunction

  initial begin
    tbl[0]  = '{0, 5, 3, 1'b1, 16'h001F};
    tbl[1]  = '{0, 5, 3, 1'b0, 16'hF800};
    tbl[2]  = '{0, 96, 3, 1'b1, 16'h0000};
    tbl[3]  = '{0, 127, 0, 1'b0, 16'h0000};
    tbl[4]  = '{0, 90, 60, 1'b0, 16'h07E0};
    tbl[5]  = '{0, 95, 63, 1'b1, 16'h07E0};
    tbl[6]  = '{0, 7, 7, 1'b0, 16'hF800};
    tbl[7]  = '{0, 8, 0, 1'b0, 16'h0000};
    tbl[8]  = '{0, 20, 20, 1'b1, 16'h0000};
    tbl[9]  = '{1, 10, 2, 1'b0, 16'hFFFF};
    tbl[10] = '{1, 26, 18, 1'b0, 16'h07E0};
    tbl[11] = '{1, 3, 3, 1'b1, 16'h001F};

    rst = 1'b1; col = 1'b0; x = '0; y = '0;
    for (int i = 0; i < 4; i++) begin
      pb[i] = 5'd0;
      en[i] = 1'b1;
    end
    tick(3);
    for (int d = 0; d < 4; d++) begin
      chk_game(d, "reset", 0, 0, 0, 0, 0);
      chk($sformatf("reset.oled%0d", d), int'(oled[d]), 0);
    end
    rst = 1'b0;
    tick(2);
    chk("post_reset.no_event", int'(st[0]), 0);

    for (int i = 0; i < 12; i++) begin
      x   = 7'(tbl[i].px);
      y   = 6'(tbl[i].py);
      col = tbl[i].c;
      tick(1);
      chk($sformatf("pix[%0d]", i), int'(oled[tbl[i].inst]), int'(tbl[i].exp));
    end

    // d0: start, held move, centre ignored in PLAY, enable drop
    press(0, 5'b00001);
    chk_game(0, "start", 1, 0, 0, 0, 0);
    pb[0] = 5'b01000;
    tick(100);
    chk_game(0, "hold_right", 1, 1, 0, 1, 0);
    pb[0] = 5'd0;
    tick(12);
    chk("hold_release.moves", int'(mv[0]), 1);
    press(0, 5'b00001);
    chk("centre_in_play.state", int'(st[0]), 1);
    press(0, 5'b10000);
    chk_game(0, "down", 1, 1, 1, 2, 0);
    en[0] = 1'b0;
    tick(1);
    chk_game(0, "en_drop", 0, 0, 0, 0, 0);
    en[0] = 1'b1;
    tick(2);

    // d1: wall and out-of-bounds blocking
    press(1, 5'b00001);
    press(1, 5'b01000);
    chk_game(1, "wall_block", 1, 0, 0, 0, 0);
    press(1, 5'b00100);
    chk_game(1, "oob_left", 1, 0, 0, 0, 0);
    press(1, 5'b00010);
    chk_game(1, "oob_up", 1, 0, 0, 0, 0);

    // d2: goal reached on the final budgeted move wins
    press(2, 5'b00001);
    press(2, 5'b01000);
    chk_game(2, "goal_step1", 1, 1, 0, 1, 0);
    press(2, 5'b01000);
    chk_game(2, "goal_won", 2, 2, 0, 2, 2);
    press(2, 5'b01000);
    press(2, 5'b10000);
    chk_game(2, "won_ignore", 2, 2, 0, 2, 2);
    press(2, 5'b00001);
    chk_game(2, "won_to_idle", 0, 0, 0, 0, 0);

    // d3: simultaneous up+down, budget exhaustion
    press(3, 5'b00001);
    press(3, 5'b10000);
    chk_game(3, "down1", 1, 0, 1, 1, 0);
    press(3, 5'b10010);
    chk_game(3, "up_over_down", 1, 0, 0, 2, 0);
    press(3, 5'b01000);
    chk_game(3, "lost_a", 3, 1, 0, 3, 0);
    press(3, 5'b00100);
    chk_game(3, "lost_ignore", 3, 1, 0, 3, 0);
    press(3, 5'b00001);
    chk_game(3, "lost_to_idle", 0, 0, 0, 0, 0);
    press(3, 5'b00001);
    press(3, 5'b01000);
    press(3, 5'b00100);
    press(3, 5'b01000);
    chk_game(3, "lost_b", 3, 1, 0, 3, 0);

    // d1: randomized presses against the reference model
    m_state = 1; m_x = 0; m_y = 0; m_moves = 0; m_wire = 0;
    for (int it = 0; it < 150; it++) begin
      logic [4:0] m;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)      m = 5'b00001 << $urandom_range(1, 4);
      else if (r < 8) m = 5'b00001;
      else            m = 5'($urandom_range(0, 31));
      pb[1] = m;
      tick(12);
      model_press(m);
      chk_game(1, $sformatf("rnd%0d", it), m_state, m_x, m_y, m_moves, m_wire);
      pb[1] = 5'd0;
      tick(12);
      x   = 7'($urandom_range(0, 127));
      y   = 6'($urandom_range(0, 63));
      col = 1'($urandom_range(0, 1));
      tick(1);
      chk($sformatf("rnd_pix%0d", it), int'(oled[1]), model_pix(int'(x), int'(y), col));
      if ($urandom_range(0, 19) == 0) begin
        en[1] = 1'b0;
        tick(3);
        en[1] = 1'b1;
        tick(1);
        m_state = 0; m_x = 0; m_y = 0; m_moves = 0; m_wire = 0;
        chk($sformatf("rnd_en%0d", it), int'(st[1]), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
